// File: rtl/clk_gen_pkg.sv
// Shared types and reset defaults for the ring-oscillator clock generator
// tuning logic and the upstream config-register block.
package clk_gen_pkg;

    localparam int TAP_W_C       = 5;
    localparam int DIV_W_C       = 8;
    localparam int DEFAULT_TAP_C = 16;
    localparam int DEFAULT_DIV_C = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        SETTLE
    } state_t;

    typedef struct packed {
        logic [TAP_W_C-1:0] tap;
        logic [DIV_W_C-1:0] div;
    } cfg_t;

endpackage

// File: rtl/clk_gen_div_counter.sv
// Programmable divide-by-2*(div_r+1) counter producing a 50%-duty clock;
// div_r is only replaced through the load port.
module clk_gen_div_counter
    import clk_gen_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_div_i,
    output logic             wrap_o,
    output logic             clk_div_o
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_r;

    assign wrap_o = (cnt == div_r);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            div_r     <= DIV_W'(DEFAULT_DIV);
            clk_div_o <= 1'b0;
        end else begin
            if (wrap_o) begin
                cnt       <= '0;
                clk_div_o <= ~clk_div_o;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Loaded on a wrap edge, so the new value governs the phase starting now
            if (load_i) begin
                div_r <= load_div_i;
            end
        end
    end

endmodule

// File: rtl/clk_gen_tune_ctrl.sv
// Tuning controller: accepts tap/divide settings by valid/ready and applies
// them together at the end of a divided-clock low phase, then settles.
module clk_gen_tune_ctrl
    import clk_gen_pkg::*;
#(
    parameter int NUM_TAPS    = 32,
    parameter int TAP_W       = 5,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_TAP = DEFAULT_TAP_C,
    parameter int DEFAULT_DIV = DEFAULT_DIV_C,
    parameter int SETTLE_CYC  = 4
) (
    input  logic             clk_i,
    input  logic             async_reset_i,
    input  logic             cfg_v_i,
    input  logic [TAP_W-1:0] cfg_tap_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic [TAP_W-1:0] tap_sel_o,
    output logic             clk_div_o,
    output logic             applied_o,
    output logic             clamp_o
);

    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             apply_edge;
    logic             wrap;
    logic [SC_W-1:0]  settle_cnt;
    logic [TAP_W-1:0] pend_tap;
    logic [DIV_W-1:0] pend_div;

    function automatic logic tap_over(input logic [TAP_W-1:0] t);
        return int'(t) >= NUM_TAPS;
    endfunction

    function automatic logic [TAP_W-1:0] sat_tap(input logic [TAP_W-1:0] t);
        return tap_over(t) ? TAP_W'(NUM_TAPS - 1) : t;
    endfunction

    clk_gen_div_counter #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (async_reset_i),
        .load_i     (apply_edge),
        .load_div_i (pend_div),
        .wrap_o     (wrap),
        .clk_div_o  (clk_div_o)
    );

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        apply_edge = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_v_i && cfg_ready_o) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_LOW;
                end
            end
            // Switch only where a low phase ends, so no runt pulse is produced
            WAIT_LOW: begin
                if (wrap && !clk_div_o) begin
                    apply_edge = 1'b1;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SC_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            cfg_ready_o <= 1'b1;
            tap_sel_o   <= TAP_W'(DEFAULT_TAP);
            applied_o   <= 1'b0;
            clamp_o     <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            cfg_ready_o <= (state_nxt == IDLE);
            applied_o   <= apply_edge;
            if (apply_edge) begin
                tap_sel_o  <= pend_tap;
                settle_cnt <= '0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (accept && tap_over(cfg_tap_i)) begin
                clamp_o <= 1'b1;
            end
        end
    end

    // Pending setting is only consumed after an accept, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pend_tap <= sat_tap(cfg_tap_i);
            pend_div <= cfg_div_i;
        end
    end

endmodule

// File: tb/tb_clk_gen_tune_ctrl.sv
// Directed bench for clk_gen_tune_ctrl with a phase-length reference model
// compared every cycle, plus hand-computed literal checks.
module tb_clk_gen_tune_ctrl;

    localparam int NUM_TAPS = 20;
    localparam int DEF_TAP  = 16;
    localparam int DEF_DIV  = 0;
    localparam int SETTLE   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_v = 1'b0;
    logic [4:0] cfg_tap = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_ready;
    logic [4:0] tap_sel;
    logic       clk_div;
    logic       applied;
    logic       clamp;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    clk_gen_tune_ctrl #(
        .NUM_TAPS    (NUM_TAPS),
        .TAP_W       (5),
        .DIV_W       (8),
        .DEFAULT_TAP (DEF_TAP),
        .DEFAULT_DIV (DEF_DIV),
        .SETTLE_CYC  (SETTLE)
    ) dut (
        .clk_i         (clk),
        .async_reset_i (rst),
        .cfg_v_i       (cfg_v),
        .cfg_tap_i     (cfg_tap),
        .cfg_div_i     (cfg_div),
        .cfg_ready_o   (cfg_ready),
        .tap_sel_o     (tap_sel),
        .clk_div_o     (clk_div),
        .applied_o     (applied),
        .clamp_o       (clamp)
    );

    always #5 clk = ~clk;

    // Reference: time left in the current divided-clock phase, pending request, settle time
    typedef struct {
        int left;
        bit clk;
        int tap;
        int div;
        bit ready;
        bit applied;
        bit clamp;
        bit pend;
        int ptap;
        int pdiv;
        int settle;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t m_reset();
        mstate_t r;
        r.left = DEF_DIV + 1;  r.clk = 1'b0;   r.tap = DEF_TAP; r.div = DEF_DIV;
        r.ready = 1'b1;        r.applied = 1'b0; r.clamp = 1'b0; r.pend = 1'b0;
        r.ptap = 0;            r.pdiv = 0;     r.settle = 0;
        return r;
    endfunction

    function automatic mstate_t m_step(mstate_t s, bit v, int t, int d);
        mstate_t n = s;
        n.applied = 1'b0;
        if (s.pend && s.left == 1 && !s.clk) begin
            n.tap = s.ptap;  n.div = s.pdiv;  n.clk = 1'b1;  n.left = s.pdiv + 1;
            n.applied = 1'b1; n.pend = 1'b0;  n.settle = SETTLE;
        end else begin
            if (s.left == 1) begin
                n.clk  = !s.clk;
                n.left = s.div + 1;
            end else begin
                n.left = s.left - 1;
            end
            if (s.settle > 0) begin
                n.settle = s.settle - 1;
                if (n.settle == 0) n.ready = 1'b1;
            end
        end
        if (s.ready && v) begin
            n.pend  = 1'b1;
            n.ptap  = (t > NUM_TAPS - 1) ? NUM_TAPS - 1 : t;
            n.pdiv  = d;
            n.ready = 1'b0;
            if (t > NUM_TAPS - 1) n.clamp = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= m_reset();
        else     m <= m_step(m, cfg_v, int'(cfg_tap), int'(cfg_div));
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("mdl_tap_sel", int'(tap_sel), m.tap);
            check("mdl_clk_div", int'(clk_div), int'(m.clk));
            check("mdl_cfg_ready", int'(cfg_ready), int'(m.ready));
            check("mdl_applied", int'(applied), int'(m.applied));
            check("mdl_clamp", int'(clamp), int'(m.clamp));
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!cfg_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", int'(cfg_ready), 1);
    endtask

    // Called at a negedge; returns posedges from accept to apply.
    task automatic do_cfg(input int t, input int d, output int lat);
        wait_ready();
        cfg_v = 1'b1; cfg_tap = 5'(t); cfg_div = 8'(d);
        @(negedge clk);
        cfg_v = 1'b0;
        check("ready_drop", int'(cfg_ready), 0);
        lat = 0;
        while (!applied && lat < 1100) begin
            @(negedge clk);
            lat++;
        end
        check("applied_seen", int'(applied), 1);
    endtask

    task automatic measure(output int hi, output int lo);
        int   k = 0;
        logic prev;
        prev = clk_div;
        @(negedge clk);
        while (!(prev == 1'b0 && clk_div == 1'b1) && k < 1100) begin
            prev = clk_div;
            @(negedge clk);
            k++;
        end
        check("rise_seen", int'(clk_div), 1);
        hi = 0;
        while (clk_div && hi < 600) begin hi++; @(negedge clk); end
        lo = 0;
        while (!clk_div && lo < 600) begin lo++; @(negedge clk); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, hi, lo, n_app, app_at, rdy_at;
        logic prev;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_tap", int'(tap_sel), 16);
        check("rst_clk_div", int'(clk_div), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_applied", int'(applied), 0);
        check("rst_clamp", int'(clamp), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Defaults: divide-by-2 toggles every cycle
        prev = clk_div;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("div2_toggle", int'(clk_div), int'(!prev));
            prev = clk_div;
        end
        check("dflt_tap", int'(tap_sel), 16);
        check("dflt_ready", int'(cfg_ready), 1);

        // Handshake tap 7 / div 3, with an ignored tap-3 request held behind it
        cfg_v = 1'b1; cfg_tap = 5'd7; cfg_div = 8'd3;
        @(negedge clk);
        check("hs_ready_low", int'(cfg_ready), 0);
        check("hs_tap_still_16", int'(tap_sel), 16);
        cfg_tap = 5'd3; cfg_div = 8'd0;
        prev = clk_div;
        n_app = 0; app_at = -1; rdy_at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 3) cfg_v = 1'b0;
            if (applied && n_app == 0) begin
                check("hs_apply_tap", int'(tap_sel), 7);
                check("hs_apply_rise", int'({prev, clk_div}), 1);
                app_at = i;
            end
            if (applied) n_app++;
            if (app_at >= 0 && rdy_at < 0 && cfg_ready) rdy_at = i;
            prev = clk_div;
        end
        check("hs_one_apply", n_app, 1);
        check("hs_latency_le2", int'(app_at >= 0 && app_at <= 1), 1);
        check("hs_ready_after4", rdy_at - app_at, 4);
        check("ign_tap_stays7", int'(tap_sel), 7);
        measure(hi, lo);
        check("div3_high", hi, 4);
        check("div3_low", lo, 4);

        // Clamp: 31 saturates to 19 and the flag is sticky
        do_cfg(31, 3, lat);
        check("clamp_tap", int'(tap_sel), 19);
        check("clamp_flag", int'(clamp), 1);
        check("clamp_lat", int'(lat <= 8), 1);
        do_cfg(2, 1, lat);
        check("post_clamp_tap", int'(tap_sel), 2);
        check("clamp_sticky", int'(clamp), 1);

        // Divide extremes
        do_cfg(5, 255, lat);
        check("d255_lat", int'(lat <= 4), 1);
        measure(hi, lo);
        check("d255_high", hi, 256);
        check("d255_low", lo, 256);
        check("d255_tap", int'(tap_sel), 5);
        do_cfg(6, 0, lat);
        check("d0_lat_le512", int'(lat >= 1 && lat <= 512), 1);
        measure(hi, lo);
        check("d0_high", hi, 1);
        check("d0_low", lo, 1);

        // Reset in WAIT_LOW discards pending tap 5
        do_cfg(9, 255, lat);
        wait_ready();
        cfg_v = 1'b1; cfg_tap = 5'd5; cfg_div = 8'd3;
        @(negedge clk);
        cfg_v = 1'b0;
        check("mr_ready_low", int'(cfg_ready), 0);
        repeat (10) @(negedge clk);
        check("mr_not_applied", int'(tap_sel), 9);
        #2 rst = 1'b1;
        #1;
        check("mr_rst_tap", int'(tap_sel), 16);
        check("mr_rst_clk_div", int'(clk_div), 0);
        check("mr_rst_ready", int'(cfg_ready), 1);
        check("mr_rst_applied", int'(applied), 0);
        check("mr_rst_clamp", int'(clamp), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_app = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (applied) n_app++;
        end
        check("mr_no_apply", n_app, 0);
        check("mr_tap_16", int'(tap_sel), 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
